// File: rtl/branch_resolve.sv
// EX-stage branch resolution: taken decision, mispredict detection, PC redirect handshake and IF/ID flush.
// Optional performance counters are enabled by defining BRANCH_STATS_EN.
module branch_resolve #(
    parameter int unsigned REG_WIDTH    = 32,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 br_valid,
    input  logic                 is_jump,
    input  logic [2:0]           funct3,
    input  logic                 pred_taken,
    input  logic [REG_WIDTH-1:0] pc_ex,
    input  logic [REG_WIDTH-1:0] target_addr,
    input  logic                 br_eq,
    input  logic                 br_lt,
    output logic                 br_un,
    output logic                 pc_write,
    output logic                 redirect_valid,
    output logic [REG_WIDTH-1:0] redirect_pc,
    input  logic                 redirect_ready,
    output logic                 flush_if,
    output logic                 flush_id,
    output logic [31:0]          stat_branches,
    output logic [31:0]          stat_mispredicts
);

    typedef enum logic [1:0] {
        IDLE,
        REDIRECT,
        FLUSH
    } state_t;

    state_t               state_q, state_d;
    logic                 redirect_valid_q, redirect_valid_d;
    logic [REG_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
    logic [3:0]           cnt_q, cnt_d;

    logic                 legal;
    logic                 taken;
    logic                 decision;
    logic                 mispredict;
    logic [REG_WIDTH-1:0] correct_pc;

    assign br_un    = funct3[1];
    assign pc_write = br_valid & (state_q == IDLE);

    always_comb begin
        legal = is_jump | ((funct3 != 3'b010) && (funct3 != 3'b011));
        taken = 1'b0;
        if (is_jump) begin
            taken = 1'b1;
        end else begin
            case (funct3)
                3'b000:         taken = br_eq;
                3'b001:         taken = ~br_eq;
                3'b100, 3'b110: taken = br_lt;
                3'b101, 3'b111: taken = ~br_lt;
                default:        taken = 1'b0;
            endcase
        end
        decision   = pc_write & legal;
        mispredict = decision & (taken != pred_taken);
        correct_pc = taken ? target_addr : pc_ex + REG_WIDTH'(4);
    end

    always_comb begin
        state_d          = state_q;
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;
        cnt_d            = cnt_q;
        case (state_q)
            IDLE: begin
                if (mispredict) begin
                    state_d          = REDIRECT;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = correct_pc;
                end
            end
            REDIRECT: begin
                if (redirect_valid_q && redirect_ready) begin
                    state_d          = FLUSH;
                    redirect_valid_d = 1'b0;
                    cnt_d            = 4'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            cnt_q            <= '0;
        end else begin
            state_q          <= state_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            cnt_q            <= cnt_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush_if       = (state_q != IDLE);
    assign flush_id       = (state_q != IDLE);

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

    // Both counters saturate rather than wrap.
    always_comb begin
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (decision && (stat_branches_q != '1)) begin
            stat_branches_d = stat_branches_q + 32'd1;
        end
        if (mispredict && (stat_mispredicts_q != '1)) begin
            stat_mispredicts_d = stat_mispredicts_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Branch resolution unit for the EX stage of the RISC-V core. It drives the branch comparator's `br_un`/`pc_write` inputs and consumes its `br_eq`/`br_lt` flags. It decides branch/jump outcome, detects misprediction against the fetch-stage guess, and issues a PC redirect to fetch over a valid/ready handshake. It then flushes IF/ID for a fixed number of cycles.

## Interface
Parameters:
- `REG_WIDTH`, `` `REG_WIDTH `` (32): data/address width.
- `FLUSH_CYCLES`, 2: cycles IF/ID flush is held after redirect handshake; legal range 1..15.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: core clock, all state on rising edge.
- `rst` in 1: synchronous active-high reset.
- `br_valid` in 1: conditional branch or jump present in EX this cycle.
- `is_jump` in 1: EX instruction is JAL/JALR (unconditional).
- `funct3` in 3: branch funct3 (BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111).
- `pred_taken` in 1: fetch-stage prediction carried with the instruction.
- `pc_ex` in REG_WIDTH: PC of EX instruction.
- `target_addr` in REG_WIDTH: computed branch/jump target.
- `br_eq` in 1, `br_lt` in 1: comparator flags.
- `br_un` out 1: unsigned-compare select to comparator.
- `pc_write` out 1: comparator enable.
- `redirect_valid` out 1, `redirect_pc` out REG_WIDTH, `redirect_ready` in 1: redirect handshake to fetch.
- `flush_if` out 1, `flush_id` out 1: kill IF/ID contents.
- `stat_branches` out 32, `stat_mispredicts` out 32: performance counters (see Configuration).

## Operation
- Combinational: `br_un = funct3[1]`; `pc_write = br_valid & (state == IDLE)`.
- Taken decision:
  - `is_jump` → taken.
  - Otherwise BEQ `br_eq`; BNE `!br_eq`; BLT/BLTU `br_lt`; BGE/BGEU `!br_lt`.
  - funct3 010/011 → not taken and never a mispredict; not counted.
- `correct_pc = taken ? target_addr : pc_ex + 4`, modulo 2^REG_WIDTH; 0xFFFFFFFC+4 wraps to 0.
- `mispredict = pc_write & legal & (taken != pred_taken)`.
- FSM states IDLE, REDIRECT, FLUSH:
  - IDLE → REDIRECT on `mispredict`. Registers `redirect_pc <= correct_pc` and sets `redirect_valid`.
  - REDIRECT holds `redirect_valid` and `redirect_pc` stable until `redirect_valid & redirect_ready`. Then it clears `redirect_valid`, loads `cnt <= FLUSH_CYCLES-1`, and goes to FLUSH.
  - FLUSH: `cnt` decrements each cycle; at `cnt == 0` → IDLE.
- `flush_if = flush_id = (state != IDLE)`.
- `br_valid` in REDIRECT/FLUSH is wrong-path: `pc_write` = 0, no decision, no counting.
- Back-to-back branches in IDLE are each evaluated.
- Reset (any state, mid-handshake included): state IDLE, `redirect_valid` 0, `redirect_pc` 0, `cnt` 0, counters 0. Flush outputs and `pc_write` follow to 0 in the same cycle.

## Timing
- `br_un`, `pc_write`: zero latency, combinational.
- Mispredict in cycle N → `redirect_valid`, `flush_if`, `flush_id` high from cycle N+1.
- Handshake completes in cycle M when `redirect_ready` is 1 → FLUSH for cycles M+1..M+FLUSH_CYCLES → IDLE at M+FLUSH_CYCLES+1.
- Minimum mispredict-to-IDLE with `redirect_ready` held high: FLUSH_CYCLES+2 cycles.
- `redirect_ready` may be high before valid; it has no effect outside REDIRECT.

## Configuration
- `BRANCH_STATS_EN` defined:
  - `stat_branches` increments on each legal `pc_write` decision.
  - `stat_mispredicts` increments on each `mispredict`.
  - Both counters saturate at 0xFFFFFFFF.
- Not defined: both ports tied to 0; no counter flops synthesized.

## Test plan
- BEQ, `br_eq`=1, `pred_taken`=0, `target_addr`=0x100 → `redirect_pc`=0x100 one cycle later; flush held 1+FLUSH_CYCLES cycles with ready high.
- BGEU, `br_lt`=1, `pred_taken`=0, `pc_ex`=0x200 → `br_un`=1, not taken, no redirect, flush stays 0.
- BNE, `br_eq`=1, `pred_taken`=1, `pc_ex`=0xFFFFFFFC → redirect to 0x00000000.
- `redirect_ready` low 5 cycles → `redirect_valid`/`redirect_pc` stable. Meanwhile `br_valid` with a mispredicting condition → `pc_write`=0, no second redirect, counters unchanged.
- `rst` asserted in REDIRECT → next cycle all outputs 0, state IDLE; following mispredict handled normally.
- With `BRANCH_STATS_EN`: 3 branches, 1 mispredict, 1 funct3=010 → `stat_branches`=3, `stat_mispredicts`=1. Without the macro both read 0.
